// File: rtl/mux_n_1_sync.sv
// Registered N:1 source mux for the VGA path; selects commit only on line/frame boundaries.
// Optional macro MUX_BLANK_ON_SWITCH_EN blanks the first full interval after every commit.
module mux_n_1_sync #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [$clog2(CHANNELS)-1:0] sel_req,
  input  logic                      sel_load,
  input  logic                      boundary,
  input  logic                      scan_en,
  input  logic [CHANNELS-1:0]       ch_mask,
  output logic [WIDTH-1:0]          out,
  output logic [$clog2(CHANNELS)-1:0] active_sel,
  output logic                      switch_pending,
  output logic                      switched
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic {ST_MANUAL = 1'b0, ST_SCAN = 1'b1} state_e;

  // Returns {found, index} of the nearest enabled channel above cur, wrapping; cur itself excluded.
  function automatic logic [SEL_W:0] next_enabled(input logic [SEL_W-1:0] cur,
                                                  input logic [CHANNELS-1:0] mask);
    logic [SEL_W:0] res;
    int             idx;
    res = '0;
    for (int step = CHANNELS - 1; step >= 1; step--) begin
      idx = (int'(cur) + step) % CHANNELS;
      if (mask[idx]) begin
        res = {1'b1, SEL_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  active_sel_q, active_sel_d;
  logic [SEL_W-1:0]  pend_sel_q, pend_sel_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              switched_q, switched_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              commit_s;
  logic              req_ok_s;
  logic [SEL_W:0]    nxt_s;
  logic [WIDTH-1:0]  chan_s;
`ifdef MUX_BLANK_ON_SWITCH_EN
  logic              blank_q, blank_d;
`endif

  assign req_ok_s = (int'(sel_req) < CHANNELS) && ch_mask[sel_req];
  assign nxt_s    = next_enabled(active_sel_q, ch_mask);
  assign chan_s   = in_bus[int'(active_sel_q)*WIDTH +: WIDTH];

  // Mode register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MANUAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next mode follows scan_en every cycle
  always_comb begin
    state_d = scan_en ? ST_SCAN : ST_MANUAL;
  end

  // Select staging, commit and scan rotation; mode-change cycles only perform the clears
  always_comb begin
    active_sel_d = active_sel_q;
    pend_sel_d   = pend_sel_q;
    pend_d       = pend_q;
    cnt_d        = cnt_q;
    commit_s     = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        if (scan_en) begin
          pend_d = 1'b0;
          cnt_d  = '0;
        end else begin
          // Commit the previously staged request before staging a same-cycle one
          if (boundary && pend_q) begin
            active_sel_d = pend_sel_q;
            pend_d       = 1'b0;
            commit_s     = 1'b1;
          end else begin
            commit_s = 1'b0;
          end
          if (sel_load && req_ok_s) begin
            pend_sel_d = sel_req;
            pend_d     = 1'b1;
          end else begin
            pend_sel_d = pend_sel_d;
          end
        end
      end
      ST_SCAN: begin
        if (!scan_en) begin
          cnt_d = '0;
        end else if (boundary) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (nxt_s[SEL_W]) begin
              active_sel_d = nxt_s[SEL_W-1:0];
              commit_s     = 1'b1;
            end else begin
              active_sel_d = active_sel_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath next values
  always_comb begin
    switched_d = commit_s;
`ifdef MUX_BLANK_ON_SWITCH_EN
    if (commit_s) begin
      blank_d = 1'b1;
    end else if (boundary) begin
      blank_d = 1'b0;
    end else begin
      blank_d = blank_q;
    end
    if (blank_q || !ch_mask[active_sel_q]) begin
      out_d = '0;
    end else begin
      out_d = chan_s;
    end
`else
    if (!ch_mask[active_sel_q]) begin
      out_d = '0;
    end else begin
      out_d = chan_s;
    end
`endif
  end

  // Datapath and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_sel_q <= '0;
      pend_sel_q   <= '0;
      pend_q       <= 1'b0;
      cnt_q        <= '0;
      switched_q   <= 1'b0;
      out_q        <= '0;
`ifdef MUX_BLANK_ON_SWITCH_EN
      blank_q      <= 1'b0;
`endif
    end else begin
      active_sel_q <= active_sel_d;
      pend_sel_q   <= pend_sel_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
      switched_q   <= switched_d;
      out_q        <= out_d;
`ifdef MUX_BLANK_ON_SWITCH_EN
      blank_q      <= blank_d;
`endif
    end
  end

  assign out            = out_q;
  assign active_sel     = active_sel_q;
  assign switch_pending = pend_q;
  assign switched       = switched_q;

endmodule

// File: tb/tb_mux_n_1_sync.sv
// Bench for mux_n_1_sync: directed vector table, hand sequences, then random traffic vs a reference model.
module tb_mux_n_1_sync;
  localparam int WIDTH = 8;
  localparam int CH = 4;
  localparam int SCAN_DIV = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [CH*WIDTH-1:0] in_bus;
  logic [1:0]          sel_req;
  logic                sel_load, boundary, scan_en;
  logic [CH-1:0]       ch_mask;
  logic [WIDTH-1:0]    out;
  logic [1:0]          active_sel;
  logic                switch_pending, switched;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model state
  int m_active, m_pend, m_psel, m_cnt, m_scan, m_blank, m_out, m_sw;

  typedef struct {
    int sr, ld, bd, scan, mask;
    int act, pend, sw, outv;
  } vec_t;
  vec_t tbl[$];

  mux_n_1_sync #(.WIDTH(WIDTH), .CHANNELS(CH), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel_req(sel_req), .sel_load(sel_load),
    .boundary(boundary), .scan_en(scan_en), .ch_mask(ch_mask), .out(out),
    .active_sel(active_sel), .switch_pending(switch_pending), .switched(switched)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int chan(input int k);
    return int'(in_bus[k*WIDTH +: WIDTH]);
  endfunction

  function automatic void add(input int sr, ld, bd, scan, mask, act, pend, sw, outv);
    vec_t v;
    v.sr = sr; v.ld = ld; v.bd = bd; v.scan = scan; v.mask = mask;
    v.act = act; v.pend = pend; v.sw = sw; v.outv = outv;
    tbl.push_back(v);
  endfunction

  task automatic model_reset();
    m_active = 0; m_pend = 0; m_psel = 0; m_cnt = 0;
    m_scan = 0; m_blank = 0; m_out = 0; m_sw = 0;
  endtask

  // Advance the model by one clock edge using the currently applied inputs
  task automatic model_step();
    int committed;
    committed = 0;
    m_out = (m_blank != 0 || ch_mask[m_active] == 1'b0) ? 0 : chan(m_active);
    if (m_scan == 0 && scan_en) begin
      m_pend = 0; m_cnt = 0;
    end else if (m_scan == 1 && !scan_en) begin
      m_cnt = 0;
    end else if (m_scan == 0) begin
      if (boundary && m_pend == 1) begin
        m_active = m_psel; m_pend = 0; committed = 1;
      end
      if (sel_load && int'(sel_req) < CH && ch_mask[sel_req]) begin
        m_psel = int'(sel_req); m_pend = 1;
      end
    end else if (boundary) begin
      if (m_cnt == SCAN_DIV - 1) begin
        m_cnt = 0;
        for (int step = 1; step < CH; step++) begin
          if (ch_mask[(m_active + step) % CH]) begin
            m_active = (m_active + step) % CH;
            committed = 1;
            break;
          end
        end
      end else begin
        m_cnt++;
      end
    end
`ifdef MUX_BLANK_ON_SWITCH_EN
    if (committed == 1) m_blank = 1;
    else if (boundary) m_blank = 0;
`endif
    m_sw = committed;
    m_scan = scan_en ? 1 : 0;
  endtask

  task automatic drive(input int sr, ld, bd, scan, mask);
    sel_req = 2'(sr); sel_load = 1'(ld); boundary = 1'(bd); scan_en = 1'(scan); ch_mask = 4'(mask);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " active_sel"}, 32'(active_sel), m_active);
    check({tag, " switch_pending"}, 32'(switch_pending), m_pend);
    check({tag, " switched"}, 32'(switched), m_sw);
    check({tag, " out"}, 32'(out), m_out);
  endtask

  int blank_exp;

  initial begin
    // sr ld bd scan mask | active pend switched out
    add(0,0,0,0,'hF, 0,0,0,'h11);
    add(2,1,0,0,'hF, 0,1,0,'h11);
    for (int i = 0; i < 4; i++) add(0,0,0,0,'hF, 0,1,0,'h11);
    add(0,0,1,0,'hF, 2,0,1,'h11);
    add(0,0,0,0,'hF, 2,0,0,'h33);
    add(1,1,0,0,'hF, 2,1,0,'h33);
    add(3,1,1,0,'hF, 1,1,1,'h33);
    add(0,0,0,0,'hF, 1,1,0,'h22);
    add(0,0,1,0,'hF, 3,0,1,'h22);
    add(0,0,0,0,'hF, 3,0,0,'h44);
    add(0,0,1,0,'hF, 3,0,0,'h44);
    add(2,1,0,0,'hB, 3,0,0,'h44);
    add(0,0,0,0,'h3, 3,0,0,'h00);
    add(0,0,0,0,'h3, 3,0,0,'h00);
    add(0,0,0,0,'hF, 3,0,0,'h44);
    add(3,1,0,0,'hF, 3,1,0,'h44);
    add(0,0,1,0,'hF, 3,0,1,'h44);
    add(0,1,0,0,'hF, 3,1,0,'h44);
    add(0,0,1,0,'hF, 0,0,1,'h44);
    add(1,1,0,0,'hF, 0,1,0,'h11);
    add(0,0,0,1,'hD, 0,0,0,'h11);
    add(1,1,1,1,'hD, 0,0,0,'h11);
    for (int i = 0; i < 2; i++) add(0,0,1,1,'hD, 0,0,0,'h11);
    add(0,0,1,1,'hD, 2,0,1,'h11);
    add(0,0,0,1,'hD, 2,0,0,'h33);
    for (int i = 0; i < 3; i++) add(0,0,1,1,'hD, 2,0,0,'h33);
    add(0,0,1,1,'hD, 3,0,1,'h33);
    add(0,0,0,1,'hD, 3,0,0,'h44);
    for (int i = 0; i < 3; i++) add(0,0,1,1,'hD, 3,0,0,'h44);
    add(0,0,1,1,'hD, 0,0,1,'h44);
    add(0,0,0,1,'hD, 0,0,0,'h11);
    add(0,0,0,0,'hD, 0,0,0,'h11);
    add(0,0,0,1,'h1, 0,0,0,'h11);
    for (int i = 0; i < 4; i++) add(0,0,1,1,'h1, 0,0,0,'h11);
    add(0,0,0,0,'hF, 0,0,0,'h11);

    rst_n = 1'b0;
    in_bus = {8'h44, 8'h33, 8'h22, 8'h11};
    drive(0,0,0,0,'hF);
    model_reset();
    #12;
    check("reset out", 32'(out), 0);
    check("reset active_sel", 32'(active_sel), 0);
    check("reset switch_pending", 32'(switch_pending), 0);
    check("reset switched", 32'(switched), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].sr, tbl[i].ld, tbl[i].bd, tbl[i].scan, tbl[i].mask);
      cycle();
      check($sformatf("vec%0d active_sel", i), 32'(active_sel), tbl[i].act);
      check($sformatf("vec%0d switch_pending", i), 32'(switch_pending), tbl[i].pend);
      check($sformatf("vec%0d switched", i), 32'(switched), tbl[i].sw);
`ifdef MUX_BLANK_ON_SWITCH_EN
      check($sformatf("vec%0d out", i), 32'(out), m_out);
`else
      check($sformatf("vec%0d out", i), 32'(out), tbl[i].outv);
`endif
    end

    // Commit to channel 1, then watch the interval that follows
`ifdef MUX_BLANK_ON_SWITCH_EN
    blank_exp = 'h00;
`else
    blank_exp = 'h22;
`endif
    drive(1,1,0,0,'hF); cycle();
    drive(0,0,1,0,'hF); cycle();
    check("blank commit active_sel", 32'(active_sel), 1);
    check("blank commit switched", 32'(switched), 1);
    drive(0,0,0,0,'hF);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check($sformatf("blank interval out %0d", i), 32'(out), blank_exp);
    end
    drive(0,0,1,0,'hF); cycle();
    check("blank boundary out", 32'(out), blank_exp);
    drive(0,0,0,0,'hF); cycle();
    check("after blank out", 32'(out), 'h22);

    // Reset mid-dwell: outputs clear asynchronously and the dwell restarts
    drive(0,0,0,1,'hF); cycle(); check_model("scan enter");
    drive(0,0,1,1,'hF);
    for (int i = 0; i < 2; i++) begin cycle(); check_model("dwell"); end
    rst_n = 1'b0;
    #2;
    check("async reset out", 32'(out), 0);
    check("async reset active_sel", 32'(active_sel), 0);
    check("async reset switch_pending", 32'(switch_pending), 0);
    check("async reset switched", 32'(switched), 0);
    model_reset();
    #2;
    rst_n = 1'b1;
    drive(0,0,0,1,'hF); cycle(); check_model("rescan enter");
    drive(0,0,1,1,'hF);
    for (int i = 0; i < SCAN_DIV; i++) begin cycle(); check_model($sformatf("rescan %0d", i)); end
    check("rescan rotated", 32'(active_sel), 1);

    // Randomised traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      in_bus = $urandom;
      sel_req = 2'($urandom);
      sel_load = ($urandom_range(0, 2) == 0);
      boundary = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) scan_en = ~scan_en;
      if ($urandom_range(0, 7) == 0) ch_mask = 4'($urandom);
      cycle();
      check_model($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
